// File: rtl/event_readout_ctrl.sv
// Event readout controller: captures a 16x64 sample window from the sampler
// and streams it as a 34-word frame (header, 32 data words, trailer).
module event_readout_ctrl #(
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter logic [15:0] HDR_MARK    = 16'hE7E7,
    parameter logic [15:0] TRL_MARK    = 16'h7E7E
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              event_ready,
    input  logic [15:0][63:0] evento,
    output logic              event_saved,
    output logic [31:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic [31:0]       event_count,
    output logic              ack_err,
    output logic              busy
);
    localparam int unsigned NUM_CH = 16;
    localparam int unsigned WORD_W = 5;
    // Counter only needs to reach ACK_TIMEOUT-1; the exit fires on that value
    localparam int unsigned ACK_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(31);

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        SEND_HDR,
        SEND_DATA,
        SEND_TRL
    } state_t;

    state_t              state_q, state_d;
    logic                rdy_meta_q, rdy_meta_d;
    logic                rdy_s_q, rdy_s_d;
    logic                armed_q, armed_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [15:0][63:0]   buf_q, buf_d;
    logic [15:0]         hit_mask_q, hit_mask_d;
    logic                event_saved_q, event_saved_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic [31:0]         m_tdata_q, m_tdata_d;
    logic                m_tlast_q, m_tlast_d;
    logic [31:0]         event_count_q, event_count_d;
    logic                ack_err_q, ack_err_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic [WORD_W-1:0]   nxt_w;
    logic [63:0]         nxt_ch;
    logic [31:0]         data_nxt;

    // Next data word: first data word after the header, else the one after word_q
    always_comb begin
        accept   = m_tvalid_q && m_tready;
        nxt_w    = (state_q == SEND_HDR) ? '0 : word_q + WORD_W'(1);
        nxt_ch   = buf_q[nxt_w[4:1]];
        data_nxt = nxt_w[0] ? nxt_ch[63:32] : nxt_ch[31:0];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rdy_meta_d    = event_ready;
        rdy_s_d       = rdy_meta_q;
        armed_d       = armed_q;
        ack_cnt_d     = ack_cnt_q;
        word_d        = word_q;
        buf_d         = buf_q;
        hit_mask_d    = hit_mask_q;
        event_saved_d = event_saved_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        m_tlast_d     = m_tlast_q;
        event_count_d = event_count_q;
        ack_err_d     = ack_err_q;

        // A low ready re-arms capture, so a stuck-high ready is taken only once
        if (!rdy_s_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (enable && rdy_s_q && armed_q) begin
                    state_d       = ACK;
                    buf_d         = evento;
                    for (int c = 0; c < int'(NUM_CH); c++) begin
                        hit_mask_d[c] = |evento[c];
                    end
                    event_saved_d = 1'b1;
                    ack_cnt_d     = '0;
                end
            end
            ACK: begin
                if (!rdy_s_q || ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    state_d       = SEND_HDR;
                    event_saved_d = 1'b0;
                    m_tvalid_d    = 1'b1;
                    m_tlast_d     = 1'b0;
                    m_tdata_d     = {HDR_MARK, event_count_q[15:0]};
                    ack_cnt_d     = '0;
                    if (rdy_s_q) begin
                        ack_err_d = 1'b1;
                        armed_d   = 1'b0;
                    end
                end else begin
                    ack_cnt_d = ack_cnt_q + ACK_W'(1);
                end
            end
            SEND_HDR: begin
                if (accept) begin
                    state_d   = SEND_DATA;
                    word_d    = '0;
                    m_tdata_d = data_nxt;
                end
            end
            SEND_DATA: begin
                if (accept) begin
                    if (word_q == LAST_WORD) begin
                        state_d   = SEND_TRL;
                        m_tdata_d = {TRL_MARK, hit_mask_q};
                        m_tlast_d = 1'b1;
                    end else begin
                        word_d    = word_q + WORD_W'(1);
                        m_tdata_d = data_nxt;
                    end
                end
            end
            SEND_TRL: begin
                if (accept) begin
                    state_d       = IDLE;
                    m_tvalid_d    = 1'b0;
                    m_tlast_d     = 1'b0;
                    m_tdata_d     = '0;
                    event_count_d = event_count_q + 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rdy_meta_q    <= 1'b0;
            rdy_s_q       <= 1'b0;
            armed_q       <= 1'b1;
            ack_cnt_q     <= '0;
            word_q        <= '0;
            buf_q         <= '0;
            hit_mask_q    <= '0;
            event_saved_q <= 1'b0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tlast_q     <= 1'b0;
            event_count_q <= '0;
            ack_err_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rdy_meta_q    <= rdy_meta_d;
            rdy_s_q       <= rdy_s_d;
            armed_q       <= armed_d;
            ack_cnt_q     <= ack_cnt_d;
            word_q        <= word_d;
            buf_q         <= buf_d;
            hit_mask_q    <= hit_mask_d;
            event_saved_q <= event_saved_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            m_tlast_q     <= m_tlast_d;
            event_count_q <= event_count_d;
            ack_err_q     <= ack_err_d;
            busy_q        <= busy_d;
        end
    end

    assign event_saved = event_saved_q;
    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign m_tlast     = m_tlast_q;
    assign event_count = event_count_q;
    assign ack_err     = ack_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Directed bench for event_readout_ctrl (ACK_TIMEOUT = 8).
module tb_event_readout_ctrl;

    logic              clk;
    logic              reset;
    logic              enable;
    logic              event_ready;
    logic [15:0][63:0] evento;
    logic              event_saved;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic [31:0]       event_count;
    logic              ack_err;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] frm [34];
    logic        lst [34];

    logic [15:0][63:0] pat_a;
    logic [15:0][63:0] pat_b;

    event_readout_ctrl #(
        .ACK_TIMEOUT(8),
        .HDR_MARK   (16'hE7E7),
        .TRL_MARK   (16'h7E7E)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .event_ready(event_ready),
        .evento     (evento),
        .event_saved(event_saved),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .event_count(event_count),
        .ack_err    (ack_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0][63:0] mk_a();
        logic [15:0][63:0] v;
        for (int c = 0; c < 16; c++) v[c] = {32'h1000_0000 + 32'(c), 32'(c)};
        v[5] = '0;
        return v;
    endfunction

    function automatic logic [15:0][63:0] mk_b();
        logic [15:0][63:0] v;
        for (int c = 0; c < 16; c++)
            v[c] = (c % 2 == 0) ? {32'hA5A5_0000 + 32'(c), 32'h5A5A_0000 + 32'(c)} : 64'h0;
        return v;
    endfunction

    // Reference frame word i for a captured window and header count
    function automatic logic [31:0] exp_word(input logic [15:0][63:0] ev, input logic [15:0] cnt, input int i);
        logic [15:0] m;
        logic [63:0] ch;
        if (i == 0) return {16'hE7E7, cnt};
        if (i == 33) begin
            for (int c = 0; c < 16; c++) m[c] = |ev[c];
            return {16'h7E7E, m};
        end
        ch = ev[4'((i - 1) / 2)];
        return ((i - 1) % 2 == 1) ? ch[63:32] : ch[31:0];
    endfunction

    // Raise event_ready, measure ack latency in edges, optionally drop ready
    task automatic send_event(input string tag, input bit drop);
        int k;
        k = 0;
        event_ready = 1'b1;
        do begin
            @(negedge clk);
            k++;
        end while (!event_saved && k < 20);
        chk({tag, "_ack_lat"}, 32'(k), 32'd3);
        if (drop) event_ready = 1'b0;
    endtask

    // Receive one frame; hook_kind 1: raise ready with pat_b, 2: drop enable, 3: reset
    task automatic frame_rx(input string tag, input bit stall, input int hook_w, input int hook_kind,
                            output int nw, output int cyc);
        int waitc, gaps, stab_err, saved_hi;
        bit tr, stalled, abort, rst_pend;
        logic [31:0] held_d;
        logic held_l;
        nw = 0; cyc = 0; waitc = 0; gaps = 0; stab_err = 0; saved_hi = 0;
        tr = 1'b0; stalled = 1'b0; abort = 1'b0; rst_pend = 1'b0;
        held_d = '0; held_l = 1'b0;
        while (!m_tvalid && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_tvalid_seen"}, 32'(m_tvalid), 32'd1);
        while (nw < 34 && cyc < 300 && !abort) begin
            if (!m_tvalid) gaps++;
            if (event_saved) saved_hi++;
            if (stalled && (m_tdata !== held_d || m_tlast !== held_l)) stab_err++;
            tr       = stall ? !tr : 1'b1;
            m_tready = tr;
            stalled  = m_tvalid && !tr;
            held_d   = m_tdata;
            held_l   = m_tlast;
            if (m_tvalid && tr) begin
                frm[nw] = m_tdata;
                lst[nw] = m_tlast;
                if (nw == hook_w) begin
                    case (hook_kind)
                        1: begin evento = pat_b; event_ready = 1'b1; end
                        2: enable = 1'b0;
                        3: begin reset = 1'b1; rst_pend = 1'b1; end
                        default: ;
                    endcase
                end
                nw++;
            end
            @(negedge clk);
            cyc++;
            if (rst_pend) begin
                chk({tag, "_rst_tvalid"}, 32'(m_tvalid), 32'd0);
                chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
                chk({tag, "_rst_count"}, event_count, 32'd0);
                chk({tag, "_rst_tlast"}, 32'(m_tlast), 32'd0);
                reset = 1'b0;
                abort = 1'b1;
            end
        end
        m_tready = 1'b0;
        chk({tag, "_gaps"}, 32'(gaps), 32'd0);
        chk({tag, "_stable"}, 32'(stab_err), 32'd0);
        chk({tag, "_no_ack_busy"}, 32'(saved_hi), 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [15:0][63:0] pat, input logic [15:0] cnt,
                               input int nw, input int cyc, input int exp_cyc);
        chk({tag, "_nwords"}, 32'(nw), 32'd34);
        chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        for (int i = 0; i < 34; i++) begin
            chk($sformatf("%s_w%0d", tag, i), frm[i], exp_word(pat, cnt, i));
            chk($sformatf("%s_last%0d", tag, i), 32'(lst[i]), (i == 33) ? 32'd1 : 32'd0);
        end
    endtask

    // Watch for n cycles; count event_saved and m_tvalid highs
    task automatic idle_watch(input string tag, input int n);
        int sv, tv;
        sv = 0; tv = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (event_saved) sv++;
            if (m_tvalid) tv++;
        end
        chk({tag, "_no_saved"}, 32'(sv), 32'd0);
        chk({tag, "_no_tvalid"}, 32'(tv), 32'd0);
    endtask

    initial begin
        int nw, cyc, n;
        pat_a       = mk_a();
        pat_b       = mk_b();
        reset       = 1'b1;
        enable      = 1'b1;
        event_ready = 1'b0;
        m_tready    = 1'b0;
        evento      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_saved", 32'(event_saved), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_count", event_count, 32'd0);
        chk("rst_ackerr", 32'(ack_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single event, full throughput
        evento = pat_a;
        send_event("t1", 1'b1);
        frame_rx("t1", 1'b0, -1, 0, nw, cyc);
        check_frame("t1", pat_a, 16'd0, nw, cyc, 34);
        chk("t1_hdr_hand", frm[0], 32'hE7E7_0000);
        chk("t1_w1_hand", frm[1], 32'h0000_0000);
        chk("t1_w2_hand", frm[2], 32'h1000_0000);
        chk("t1_trl_hand", frm[33], 32'h7E7E_FFDF);
        chk("t1_count", event_count, 32'd1);
        chk("t1_ackerr", 32'(ack_err), 32'd0);

        // Backpressure with m_tready toggling
        send_event("t2", 1'b1);
        frame_rx("t2", 1'b1, -1, 0, nw, cyc);
        check_frame("t2", pat_a, 16'd1, nw, cyc, 67);
        chk("t2_count", event_count, 32'd2);

        // Second event raised mid-frame is held off until IDLE
        send_event("t3", 1'b1);
        frame_rx("t3a", 1'b0, 11, 1, nw, cyc);
        check_frame("t3a", pat_a, 16'd2, nw, cyc, 34);
        @(negedge clk);
        chk("t3_ack_after_trl", 32'(event_saved), 32'd1);
        event_ready = 1'b0;
        frame_rx("t3b", 1'b0, -1, 0, nw, cyc);
        check_frame("t3b", pat_b, 16'd3, nw, cyc, 34);
        chk("t3b_trl_hand", frm[33], 32'h7E7E_5555);
        chk("t3_count", event_count, 32'd4);

        // Stuck-high event_ready: timeout, frame still sent, single capture
        evento = pat_a;
        send_event("t4", 1'b0);
        n = 0;
        while (!m_tvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_ack_len", 32'(n), 32'd8);
        chk("t4_ackerr", 32'(ack_err), 32'd1);
        chk("t4_saved_low", 32'(event_saved), 32'd0);
        frame_rx("t4", 1'b0, -1, 0, nw, cyc);
        check_frame("t4", pat_a, 16'd4, nw, cyc, 34);
        idle_watch("t4_stuck", 10);
        event_ready = 1'b0;
        repeat (4) @(negedge clk);
        send_event("t4r", 1'b1);
        frame_rx("t4r", 1'b0, -1, 0, nw, cyc);
        check_frame("t4r", pat_a, 16'd5, nw, cyc, 34);
        chk("t4_count", event_count, 32'd6);
        chk("t4_ackerr_sticky", 32'(ack_err), 32'd1);

        // enable low blocks capture; dropping it mid-frame lets the frame finish
        enable      = 1'b0;
        event_ready = 1'b1;
        idle_watch("t5_dis", 10);
        event_ready = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        send_event("t5", 1'b1);
        frame_rx("t5", 1'b0, 5, 2, nw, cyc);
        check_frame("t5", pat_a, 16'd6, nw, cyc, 34);
        chk("t5_count", event_count, 32'd7);
        event_ready = 1'b1;
        idle_watch("t5_after", 10);
        event_ready = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;

        // Reset during data word 10 abandons the frame
        send_event("t6", 1'b1);
        frame_rx("t6", 1'b0, 11, 3, nw, cyc);
        chk("t6_nwords", 32'(nw), 32'd12);
        idle_watch("t6_post", 5);
        send_event("t6n", 1'b1);
        frame_rx("t6n", 1'b0, -1, 0, nw, cyc);
        check_frame("t6n", pat_a, 16'd0, nw, cyc, 34);
        chk("t6n_hdr_hand", frm[0], 32'hE7E7_0000);
        chk("t6_count", event_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
